// File: rtl/clock_tick_pkg.sv
// Shared types and constants for the slow-clock tick receiver.
package clock_tick_pkg;

  // Receiver life cycle: waiting for a first edge, measuring, stable, or starved of edges.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } tick_state_t;

  localparam int CNT_W_DEFAULT = 28;

  // True in the states where rises produce period samples and the timeout is armed.
  function automatic logic is_tracking(input tick_state_t s);
    return (s == MEASURE) || (s == LOCKED);
  endfunction

endpackage

// File: rtl/clock_tick_receiver_edge_sync.sv
// edge_sync: brings an asynchronous level into the clk domain through a
// SYNC_STAGES flop chain, then compares the synchronised level with its
// one-cycle-old copy to produce combinational rise/fall strobes.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Synchroniser chain plus the delayed copy used for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign rise = chain[SYNC_STAGES-1] & ~prev;
  assign fall = ~chain[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/clock_tick_receiver.sv
// clock_tick_receiver: turns the divided game clock into one-cycle tick
// enables in the clock_in domain, measures its period and tracks lock/loss.
// Optional feature macro: TICK_PERIOD_MEAS_EN enables period measurement and
// the tolerance check; without it every rise is accepted and period reads 0.
// The state output exposes the FSM for debug and checkers.
module clock_tick_receiver
  import clock_tick_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int TIMEOUT     = 4096,
  parameter int LOCK_EDGES  = 3,
  parameter int TOL         = 4
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             slow_clk_in,
  output logic             tick,
  output logic             locked,
  output logic             lost,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output tick_state_t      state
);

  localparam int               LOCK_W      = $clog2(LOCK_EDGES + 1);
  localparam logic [LOCK_W-1:0] LOCK_FULL  = LOCK_W'(LOCK_EDGES);
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic              rise;
  logic              unused_fall;
  logic [CNT_W-1:0]  count;
  logic [LOCK_W-1:0] lock_cnt;
  logic [LOCK_W-1:0] lock_next;
  tick_state_t       state_next;
  logic              accepted;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clock_in),
    .reset (reset),
    .din   (slow_clk_in),
    .rise  (rise),
    .fall  (unused_fall)
  );

  // Cycles since the last rise: restarts at 1 on a rise, sticks at all-ones.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      count <= '0;
    end else if (rise) begin
      count <= CNT_W'(1);
    end else if (count != CNT_MAX) begin
      count <= count + CNT_W'(1);
    end
  end

  // Registered tick: one pulse per detected rise, in every state.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      tick <= 1'b0;
    end else begin
      tick <= rise;
    end
  end

  // State and lock-count registers.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else begin
      state    <= state_next;
      lock_cnt <= lock_next;
    end
  end

  // Next state: a rise always beats a timeout landing in the same cycle.
  always_comb begin
    state_next = state;
    lock_next  = lock_cnt;
    case (state)
      IDLE, LOST: begin
        // The rise that (re)starts measurement has no valid reference.
        if (rise) state_next = MEASURE;
      end
      MEASURE, LOCKED: begin
        if (rise) begin
          if (accepted) begin
            if (lock_cnt != LOCK_FULL) lock_next = lock_cnt + LOCK_W'(1);
          end else begin
            lock_next = '0;
          end
          state_next = (lock_next == LOCK_FULL) ? LOCKED : MEASURE;
        end else if (count == CNT_TIMEOUT) begin
          state_next = LOST;
          lock_next  = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign locked = (state == LOCKED);
  assign lost   = (state == LOST);

`ifdef TICK_PERIOD_MEAS_EN
  localparam logic [CNT_W:0] TOL_LIM = (CNT_W + 1)'(TOL);

  logic               capture;
  logic signed [CNT_W:0] diff;
  logic [CNT_W:0]     mag;

  // A period is sampled only on rises that close a measured interval.
  assign capture = rise & is_tracking(state);

  // |count - previous period| with one extra bit so the sign survives.
  always_comb begin
    diff     = $signed({1'b0, count}) - $signed({1'b0, period});
    mag      = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    accepted = (mag <= TOL_LIM);
  end

  // Period register doubles as the previous-period reference.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= capture;
      if (capture) period <= count;
    end
  end
`else
  // Tolerance has no meaning without period measurement.
  localparam int unused_tol = TOL;

  assign accepted     = 1'b1;
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_clock_tick_receiver.sv
// Bench for clock_tick_receiver: edge-indexed reference model, one task per scenario.
module tb_clock_tick_receiver;
  import clock_tick_pkg::*;

  localparam int SYNC       = 2;
  localparam int CNT_W      = 28;
  localparam int TIMEOUT    = 4096;
  localparam int LOCK_EDGES = 3;
  localparam int TOL        = 4;
`ifdef TICK_PERIOD_MEAS_EN
  localparam int MEAS = 1;
`else
  localparam int MEAS = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic slow_clk_in = 1'b0;
  always #5 clk = ~clk;

  logic             tick, locked, lost, period_valid;
  logic [CNT_W-1:0] period;
  tick_state_t      state;

  clock_tick_receiver #(
    .SYNC_STAGES(SYNC), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT),
    .LOCK_EDGES(LOCK_EDGES), .TOL(TOL)
  ) dut (
    .clock_in     (clk),
    .reset        (reset),
    .slow_clk_in  (slow_clk_in),
    .tick         (tick),
    .locked       (locked),
    .lost         (lost),
    .period       (period),
    .period_valid (period_valid),
    .state        (state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  // Works on edge indices: a rise is registered SYNC+1 edges after the
  // sampling edge, and a period is the edge distance between two rises.
  tick_state_t       m_state  = IDLE;
  int                m_acc    = 0;
  int                m_last   = 0;
  logic              m_tick   = 1'b0;
  logic              m_pv     = 1'b0;
  logic [CNT_W-1:0]  m_period = '0;
  logic [SYNC+1:0]   m_hist   = '0;

  logic [CNT_W+5:0] got_vec;
  logic [CNT_W+5:0] exp_vec;
  assign got_vec = {state, tick, locked, lost, period_valid, period};
  assign exp_vec = {m_state, m_tick, m_state == LOCKED, m_state == LOST, m_pv, m_period};

  task automatic model_edge();
    logic rise;
    logic ok;
`ifdef TICK_PERIOD_MEAS_EN
    int p;
    int d;
`endif
    cyc++;
    if (reset) begin
      m_hist = '0; m_state = IDLE; m_acc = 0;
      m_tick = 1'b0; m_pv = 1'b0; m_period = '0;
    end else begin
      m_hist = {m_hist[SYNC:0], slow_clk_in};
      rise   = m_hist[SYNC] & ~m_hist[SYNC+1];
      m_tick = rise;
      m_pv   = 1'b0;
      if (rise) begin
        if (m_state == IDLE || m_state == LOST) begin
          m_state = MEASURE;
        end else begin
`ifdef TICK_PERIOD_MEAS_EN
          p = cyc - m_last;
          d = p - int'(m_period);
          if (d < 0) d = -d;
          ok = (d <= TOL);
          m_period = CNT_W'(p);
          m_pv = 1'b1;
`else
          ok = 1'b1;
`endif
          if (!ok) m_acc = 0;
          else if (m_acc < LOCK_EDGES) m_acc = m_acc + 1;
          m_state = (m_acc == LOCK_EDGES) ? LOCKED : MEASURE;
        end
        m_last = cyc;
      end else if ((m_state == MEASURE || m_state == LOCKED) && (cyc - m_last == TIMEOUT)) begin
        m_state = LOST;
        m_acc   = 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change at negedge; model and DUT both see them at the next posedge.
  task automatic step(input logic v, input logic r);
    slow_clk_in = v;
    reset       = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int first_tick;
    for (int i = 0; i < 40; i++) begin
      step(((i / 3) % 2) == 1, 1'b1);
      total++;
      if (got_vec !== exp_vec) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", cyc, got_vec, exp_vec);
      end
    end
    first_tick = 0;
    for (int c = 1; c <= 12; c++) begin
      step(1'b1, 1'b0);
      if (tick === 1'b1 && first_tick == 0) first_tick = c;
      total++;
      if (got_vec !== exp_vec) begin
        bad++;
        $display("FAIL first_tick_cycle cyc=%0d got=%h want=%h", cyc, got_vec, exp_vec);
      end
    end
    total++;
    if (first_tick !== SYNC + 1) begin
      bad++;
      $display("FAIL first_tick_latency got=%0d want=%0d", first_tick, SYNC + 1);
    end
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0);
      total++;
      if (got_vec !== exp_vec) begin
        bad++;
        $display("FAIL reset_tail cyc=%0d got=%h want=%h", cyc, got_vec, exp_vec);
      end
    end
  endtask

  task automatic test_square();
    int tick_no, last_tick, lock_at;
    tick_no = 0; last_tick = 0; lock_at = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 2001; c++) begin
        step(c < 1000, 1'b0);
        total++;
        if (got_vec !== exp_vec) begin
          bad++;
          $display("FAIL square_cycle cyc=%0d got=%h want=%h", cyc, got_vec, exp_vec);
        end
        if (tick === 1'b1) begin
          tick_no++;
          if (tick_no >= 2) begin
            total++;
            if (cyc - last_tick !== 2001) begin
              bad++;
              $display("FAIL square_spacing got=%0d want=2001", cyc - last_tick);
            end
          end
          if (tick_no == 2) begin
            total++;
            if (period !== CNT_W'(MEAS ? 2001 : 0) || period_valid !== 1'(MEAS)) begin
              bad++;
              $display("FAIL square_period got=%0d/%b want=%0d/%0d", period, period_valid,
                       MEAS ? 2001 : 0, MEAS);
            end
          end
          last_tick = cyc;
        end
        if (locked === 1'b1 && lock_at == 0) lock_at = tick_no;
      end
    end
    total++;
    if (lock_at !== (MEAS ? 5 : 4)) begin
      bad++;
      $display("FAIL square_lock_tick got=%0d want=%0d", lock_at, MEAS ? 5 : 4);
    end
  endtask

  task automatic test_timeout();
    int lens[$];
    logic lvs[$];
    int last_tick;
    logic lost_seen, back_checked;
    last_tick = 0; lost_seen = 1'b0; back_checked = 1'b0;
    for (int k = 0; k < 5; k++) begin
      lens.push_back(1000); lvs.push_back(1'b1);
      lens.push_back(1001); lvs.push_back(1'b0);
    end
    lens.push_back(5000); lvs.push_back(1'b1);
    lens.push_back(1001); lvs.push_back(1'b0);
    for (int k = 0; k < 2; k++) begin
      lens.push_back(1000); lvs.push_back(1'b1);
      lens.push_back(1001); lvs.push_back(1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    foreach (lens[s]) begin
      for (int c = 0; c < lens[s]; c++) begin
        step(lvs[s], 1'b0);
        total++;
        if (got_vec !== exp_vec) begin
          bad++;
          $display("FAIL timeout_cycle cyc=%0d got=%h want=%h", cyc, got_vec, exp_vec);
        end
        if (tick === 1'b1 && lost_seen && !back_checked) begin
          back_checked = 1'b1;
          total++;
          if (lost !== 1'b0 || state !== MEASURE) begin
            bad++;
            $display("FAIL timeout_recover got lost=%b state=%0d want lost=0 state=%0d",
                     lost, state, MEASURE);
          end
        end
        if (tick === 1'b1) last_tick = cyc;
        if (lost === 1'b1 && !lost_seen) begin
          lost_seen = 1'b1;
          total++;
          if (cyc - last_tick !== TIMEOUT || locked !== 1'b0) begin
            bad++;
            $display("FAIL timeout_latency got=%0d locked=%b want=%0d locked=0",
                     cyc - last_tick, locked, TIMEOUT);
          end
        end
      end
    end
    total++;
    if (!lost_seen || !back_checked) begin
      bad++;
      $display("FAIL timeout_seen got lost_seen=%b recovered=%b want 1/1", lost_seen, back_checked);
    end
  endtask

  task automatic test_period_change();
    int tick_no, relock_at;
    int per;
    tick_no = 0; relock_at = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      per = (k == 7) ? 2010 : 2001;
      for (int c = 0; c < per; c++) begin
        step(c < 1000, 1'b0);
        total++;
        if (got_vec !== exp_vec) begin
          bad++;
          $display("FAIL change_cycle cyc=%0d got=%h want=%h", cyc, got_vec, exp_vec);
        end
        if (tick === 1'b1) begin
          tick_no++;
          if (tick_no == 8) begin
            total++;
            if (locked !== 1'(1 - MEAS)) begin
              bad++;
              $display("FAIL change_drop got=%b want=%0d", locked, 1 - MEAS);
            end
          end
          if (tick_no > 8 && locked === 1'b1 && relock_at == 0) relock_at = tick_no;
        end
      end
    end
    total++;
    if (relock_at !== (MEAS ? 12 : 9)) begin
      bad++;
      $display("FAIL change_relock got=%0d want=%0d", relock_at, MEAS ? 12 : 9);
    end
  endtask

  // Starts from the locked state left by test_period_change.
  task automatic test_reset_mid();
    for (int c = 0; c < 700; c++) begin
      step(1'b1, 1'b0);
      total++;
      if (got_vec !== exp_vec) begin
        bad++;
        $display("FAIL midreset_pre cyc=%0d got=%h want=%h", cyc, got_vec, exp_vec);
      end
    end
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL midreset_locked got=%b want=1", locked);
    end
    step(1'b1, 1'b1);
    total++;
    if (got_vec !== '0) begin
      bad++;
      $display("FAIL midreset_clear got=%h want=0", got_vec);
    end
    for (int c = 0; c < 3300; c++) begin
      step(c < 300 || (c >= 1301 && c < 2301), 1'b0);
      total++;
      if (got_vec !== exp_vec) begin
        bad++;
        $display("FAIL midreset_post cyc=%0d got=%h want=%h", cyc, got_vec, exp_vec);
      end
    end
  endtask

  task automatic test_irregular();
    int pers[6];
    int tick_no, lock_at, hi;
    pers = '{500, 3000, 900, 500, 3000, 900};
    tick_no = 0; lock_at = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    foreach (pers[k]) begin
      hi = pers[k] / 2;
      for (int c = 0; c < pers[k]; c++) begin
        step(c < hi, 1'b0);
        total++;
        if (got_vec !== exp_vec) begin
          bad++;
          $display("FAIL irregular_cycle cyc=%0d got=%h want=%h", cyc, got_vec, exp_vec);
        end
        if (tick === 1'b1) tick_no++;
        if (locked === 1'b1 && lock_at == 0) lock_at = tick_no;
      end
    end
    total++;
    if (lock_at !== (MEAS ? 0 : 4)) begin
      bad++;
      $display("FAIL irregular_lock_tick got=%0d want=%0d", lock_at, MEAS ? 0 : 4);
    end
    total++;
    if (period !== CNT_W'(MEAS ? 3000 : 0)) begin
      bad++;
      $display("FAIL irregular_period got=%0d want=%0d", period, MEAS ? 3000 : 0);
    end
  endtask

  task automatic test_random();
    int per, hi;
    logic rst;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      if (k == 20) per = 4300;
      else if ($urandom_range(0, 9) == 0) per = int'($urandom_range(4, 20));
      else per = 50 + int'($urandom_range(0, 8));
      hi = int'($urandom_range(1, per - 1));
      rst = ($urandom_range(0, 15) == 0);
      for (int c = 0; c < per; c++) begin
        step(c < hi, rst && (c < 2));
        total++;
        if (got_vec !== exp_vec) begin
          bad++;
          $display("FAIL random_cycle cyc=%0d got=%h want=%h", cyc, got_vec, exp_vec);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_square();
    test_timeout();
    test_period_change();
    test_reset_mid();
    test_irregular();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
